fifo_rx_ctrl: RTL and testbench
===============================

Name: fifo_rx_ctrl

Overview:
Parametrised successor to the UART receive FIFO: a synchronous single-clock FIFO of configurable depth and width, with a selectable read mode (registered or first-word-fall-through). It adds occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. It sits between the UART receiver (write side) and the command/instruction decoder (read side).

Parameters:
FIFO_DEPTH, 256, number of entries; power of two, >= 4
FIFO_DATA_WIDTH, 8, bits per entry
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through
AF_LEVEL, FIFO_DEPTH-4, almost_full asserted when count >= AF_LEVEL; range 1..FIFO_DEPTH
AE_LEVEL, 4, almost_empty asserted when count <= AE_LEVEL; range 0..FIFO_DEPTH-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
we  in  1  write enable
valid  in  1  write data qualifier; a write requires we && valid
w_data  in  FIFO_DATA_WIDTH  write data
re  in  1  read request / pop
flush  in  1  synchronous clear of contents and error flags
r_data  out  FIFO_DATA_WIDTH  read data
r_valid  out  1  r_data holds a popped word (FWFT=0: 1-cycle pulse; FWFT=1: equals !empty)
empty  out  1  count == 0
full  out  1  count == FIFO_DEPTH
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  $clog2(FIFO_DEPTH)+1  current occupancy
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- Pointers are $clog2(FIFO_DEPTH)+1 bits wide, with an extra wrap MSB. empty = (w_ptr == r_ptr); full = (MSBs differ, lower bits equal); count = w_ptr - r_ptr (modulo arithmetic).
- Reset (async, rst=1): w_ptr = r_ptr = 0, r_data = 0, r_valid = 0, overflow = underflow = 0. This yields empty=1, full=0, count=0, almost_empty=1, almost_full=0. Memory contents are not reset.
- write_ok = we && valid && !full; read_ok = re && !empty. Flags are evaluated on registered state, so a write is refused when full even if a read occurs in the same cycle. A read is refused when empty even if a write occurs in the same cycle.
- On write_ok: mem[w_ptr low bits] <= w_data; w_ptr += 1.
- On read_ok: r_ptr += 1.
- Simultaneous write_ok and read_ok: both pointers advance; count is unchanged.
- Pointer wrap: low bits roll over from FIFO_DEPTH-1 to 0 and the MSB toggles. No data loss occurs across the wrap.
- FWFT=0 read timing:
  - On read_ok, r_data <= head word and r_valid <= 1 for exactly one cycle.
  - When there is no read_ok, r_valid <= 0 and r_data holds its last value.
- FWFT=1 read timing:
  - r_data = mem[r_ptr low bits] combinationally; r_valid = !empty.
  - re acts as a pop (acknowledge). A word written into an empty FIFO appears on r_data the cycle after the write.
- Status flags: all are combinational from registered pointers and update the cycle after the causing edge.
- overflow is set on (we && valid && full). underflow is set on (re && empty). Both hold until flush or rst.
- flush (synchronous): w_ptr = r_ptr = 0, overflow = underflow = 0, r_valid = 0, r_data unchanged.
  - Flush takes priority over any write, read, or error event in the same cycle; none of those take effect.
- rst asserted mid-operation immediately forces the reset values, regardless of clk.

Test Plan:
- DEPTH=8, FWFT=0: write 0x11,0x22,0x33, then re for 3 cycles -> r_valid pulses on the cycle after each re, with r_data 0x11, 0x22, 0x33; empty=1 afterwards; count goes 3→0.
- DEPTH=8: write 8 words (0x00..0x07) -> full=1 and count=8 after the 8th write; a 9th write of 0xAA -> overflow=1, count stays 8; draining returns 0x00..0x07 with no 0xAA.
- DEPTH=8, FWFT=1: write 0x5A into an empty FIFO -> next cycle r_data=0x5A and r_valid=1; pulse re -> empty=1 and r_valid=0.
- DEPTH=8, AF_LEVEL=6, AE_LEVEL=1: fill one word at a time -> almost_empty deasserts at count=2, almost_full asserts at count=6; simultaneous we&&valid and re at count=5 -> count stays 5.
- Wrap: 20 write/read pairs with incrementing data on DEPTH=8 -> every read matches the write order; pointer MSB toggles with no spurious full or empty.
- re on empty -> underflow=1. Then flush asserted together with we=valid=1 -> count=0, overflow=underflow=0, write discarded. Async rst mid-burst -> outputs at reset values before the next clk edge.

Source files
------------

// File: rtl/fifo_rx_ctrl.sv
// Single-clock receive FIFO between the UART receiver and the decoder.
// Registered or first-word-fall-through read, occupancy and sticky error flags.
module fifo_rx_ctrl #(
    parameter int FIFO_DEPTH      = 256,
    parameter int FIFO_DATA_WIDTH = 8,
    parameter int FWFT            = 0,
    parameter int AF_LEVEL        = FIFO_DEPTH - 4,
    parameter int AE_LEVEL        = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic                         valid,
    input  logic [FIFO_DATA_WIDTH-1:0]   w_data,
    input  logic                         re,
    input  logic                         flush,
    output logic [FIFO_DATA_WIDTH-1:0]   r_data,
    output logic                         r_valid,
    output logic                         empty,
    output logic                         full,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]              w_ptr;
    logic [PW-1:0]              r_ptr;
    logic                       write_ok;
    logic                       read_ok;

    // Extra MSB on each pointer distinguishes full from empty.
    assign empty        = (w_ptr == r_ptr);
    assign full         = (w_ptr[AW] != r_ptr[AW]) &&
                          (w_ptr[AW-1:0] == r_ptr[AW-1:0]);
    assign count        = w_ptr - r_ptr;
    assign almost_full  = (count >= PW'(AF_LEVEL));
    assign almost_empty = (count <= PW'(AE_LEVEL));

    assign write_ok = we && valid && !full;
    assign read_ok  = re && !empty;

    always_ff @(posedge clk) begin
        if (write_ok && !flush) begin
            mem[w_ptr[AW-1:0]] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (write_ok) begin
                w_ptr <= w_ptr + 1'b1;
            end
            if (read_ok) begin
                r_ptr <= r_ptr + 1'b1;
            end
            if (we && valid && full) begin
                overflow <= 1'b1;
            end
            if (re && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign r_data  = mem[r_ptr[AW-1:0]];
            assign r_valid = !empty;
        end else begin : g_reg
            logic [FIFO_DATA_WIDTH-1:0] r_data_q;
            logic                       r_valid_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data_q  <= '0;
                    r_valid_q <= 1'b0;
                end else if (flush) begin
                    r_valid_q <= 1'b0;
                end else if (read_ok) begin
                    r_data_q  <= mem[r_ptr[AW-1:0]];
                    r_valid_q <= 1'b1;
                end else begin
                    r_valid_q <= 1'b0;
                end
            end

            assign r_data  = r_data_q;
            assign r_valid = r_valid_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_rx_ctrl.sv
// Directed bench: registered-read instance with custom levels,
// plus a first-word-fall-through instance.
module tb_fifo_rx_ctrl;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int CW    = 4;

    logic clk = 1'b0;
    logic rst;

    logic          a_we, a_valid, a_re, a_flush;
    logic [DW-1:0] a_w_data, a_r_data;
    logic          a_r_valid, a_empty, a_full, a_af, a_ae;
    logic [CW-1:0] a_count;
    logic          a_ovf, a_udf;

    logic          b_we, b_valid, b_re, b_flush;
    logic [DW-1:0] b_w_data, b_r_data;
    logic          b_r_valid, b_empty, b_full, b_af, b_ae;
    logic [CW-1:0] b_count;
    logic          b_ovf, b_udf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_rx_ctrl #(
        .FIFO_DEPTH(DEPTH), .FIFO_DATA_WIDTH(DW), .FWFT(0),
        .AF_LEVEL(6), .AE_LEVEL(1)
    ) dut_a (
        .clk(clk), .rst(rst), .we(a_we), .valid(a_valid),
        .w_data(a_w_data), .re(a_re), .flush(a_flush),
        .r_data(a_r_data), .r_valid(a_r_valid), .empty(a_empty),
        .full(a_full), .almost_full(a_af), .almost_empty(a_ae),
        .count(a_count), .overflow(a_ovf), .underflow(a_udf)
    );

    fifo_rx_ctrl #(
        .FIFO_DEPTH(DEPTH), .FIFO_DATA_WIDTH(DW), .FWFT(1)
    ) dut_b (
        .clk(clk), .rst(rst), .we(b_we), .valid(b_valid),
        .w_data(b_w_data), .re(b_re), .flush(b_flush),
        .r_data(b_r_data), .r_valid(b_r_valid), .empty(b_empty),
        .full(b_full), .almost_full(b_af), .almost_empty(b_ae),
        .count(b_count), .overflow(b_ovf), .underflow(b_udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_we = 0; a_valid = 0; a_re = 0; a_flush = 0;
    endtask

    task automatic a_push(input logic [DW-1:0] d);
        a_we = 1; a_valid = 1; a_w_data = d; a_re = 0;
        step();
        a_idle();
    endtask

    task automatic a_pop_chk(input string tag, input logic [DW-1:0] d);
        a_re = 1;
        step();
        a_re = 0;
        chk({tag, "_rv"}, 32'(a_r_valid), 32'd1);
        chk({tag, "_rd"}, 32'(a_r_data), 32'(d));
    endtask

    initial begin
        rst = 1;
        a_idle(); a_w_data = '0;
        b_we = 0; b_valid = 0; b_re = 0; b_flush = 0; b_w_data = '0;
        #3;
        chk("rst_empty", 32'(a_empty), 32'd1);
        chk("rst_full",  32'(a_full),  32'd0);
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_ae",    32'(a_ae),    32'd1);
        chk("rst_af",    32'(a_af),    32'd0);
        chk("rst_rv",    32'(a_r_valid), 32'd0);
        chk("rst_rd",    32'(a_r_data),  32'd0);
        chk("rst_ovf",   32'(a_ovf),   32'd0);
        chk("rst_udf",   32'(a_udf),   32'd0);
        chk("rst_b_rv",  32'(b_r_valid), 32'd0);
        @(negedge clk);
        rst = 0;

        // Registered read of three words.
        a_push(8'h11);
        chk("t1_cnt1", 32'(a_count), 32'd1);
        a_push(8'h22);
        a_push(8'h33);
        chk("t1_cnt3", 32'(a_count), 32'd3);
        a_pop_chk("t1_p0", 8'h11);
        chk("t1_cnt2", 32'(a_count), 32'd2);
        a_pop_chk("t1_p1", 8'h22);
        a_pop_chk("t1_p2", 8'h33);
        chk("t1_cnt0",  32'(a_count), 32'd0);
        chk("t1_empty", 32'(a_empty), 32'd1);
        step();
        chk("t1_rv_low", 32'(a_r_valid), 32'd0);
        chk("t1_rd_hold", 32'(a_r_data), 32'h33);

        // Fill to full, check level flags at every count.
        for (int i = 0; i < DEPTH; i++) begin
            a_push(8'(i));
            chk("fill_cnt",  32'(a_count), 32'(i + 1));
            chk("fill_ae",   32'(a_ae),   32'((i + 1) <= 1));
            chk("fill_af",   32'(a_af),   32'((i + 1) >= 6));
            chk("fill_full", 32'(a_full), 32'((i + 1) == DEPTH));
        end
        a_push(8'hAA);
        chk("ovf_set",  32'(a_ovf),   32'd1);
        chk("ovf_cnt",  32'(a_count), 32'd8);
        for (int i = 0; i < DEPTH; i++) begin
            a_pop_chk("drain", 8'(i));
        end
        chk("drain_empty", 32'(a_empty), 32'd1);
        chk("ovf_sticky",  32'(a_ovf),   32'd1);

        // Simultaneous write and read at count 5.
        for (int i = 0; i < 5; i++) a_push(8'(8'h40 + i));
        a_we = 1; a_valid = 1; a_w_data = 8'h45; a_re = 1;
        step();
        a_idle();
        chk("sim_cnt", 32'(a_count),   32'd5);
        chk("sim_rd",  32'(a_r_data),  32'h40);
        chk("sim_rv",  32'(a_r_valid), 32'd1);
        for (int i = 1; i < 6; i++) a_pop_chk("sim_drain", 8'(8'h40 + i));

        // Underflow, then flush beats a concurrent write.
        a_re = 1;
        step();
        a_re = 0;
        chk("udf_set", 32'(a_udf),     32'd1);
        chk("udf_rv",  32'(a_r_valid), 32'd0);
        a_we = 1; a_valid = 1; a_w_data = 8'hEE; a_re = 1; a_flush = 1;
        step();
        a_idle();
        chk("fl_cnt",   32'(a_count), 32'd0);
        chk("fl_empty", 32'(a_empty), 32'd1);
        chk("fl_ovf",   32'(a_ovf),   32'd0);
        chk("fl_udf",   32'(a_udf),   32'd0);
        chk("fl_rd",    32'(a_r_data), 32'h45);

        // Wrap: 23 words through an 8-deep FIFO with 3 in flight.
        for (int i = 0; i < 3; i++) a_push(8'(8'h80 + i));
        for (int i = 0; i < 20; i++) begin
            a_we = 1; a_valid = 1; a_w_data = 8'(8'h83 + i); a_re = 1;
            step();
            chk("wr_rd",  32'(a_r_data), 32'(8'h80 + i));
            chk("wr_cnt", 32'(a_count),  32'd3);
            chk("wr_flg", 32'({a_full, a_empty}), 32'd0);
        end
        a_idle();
        for (int i = 20; i < 23; i++) a_pop_chk("wr_drain", 8'(8'h80 + i));
        chk("wr_empty", 32'(a_empty), 32'd1);

        // FWFT instance.
        b_we = 1; b_valid = 1; b_w_data = 8'h5A;
        step();
        b_we = 0; b_valid = 0;
        chk("fw_rd",  32'(b_r_data),  32'h5A);
        chk("fw_rv",  32'(b_r_valid), 32'd1);
        chk("fw_cnt", 32'(b_count),   32'd1);
        b_re = 1;
        step();
        b_re = 0;
        chk("fw_empty", 32'(b_empty),   32'd1);
        chk("fw_rv0",   32'(b_r_valid), 32'd0);
        b_we = 1; b_valid = 1; b_w_data = 8'hA1;
        step();
        b_w_data = 8'hA2;
        step();
        b_we = 0; b_valid = 0;
        chk("fw_head1", 32'(b_r_data), 32'hA1);
        b_re = 1;
        step();
        b_re = 0;
        chk("fw_head2", 32'(b_r_data), 32'hA2);
        chk("fw_cnt1",  32'(b_count),  32'd1);

        // Asynchronous reset between clock edges.
        a_push(8'h01);
        a_push(8'h02);
        a_re = 1;
        step();
        a_re = 0;
        chk("ar_pre_rv", 32'(a_r_valid), 32'd1);
        #2;
        rst = 1;
        #1;
        chk("ar_cnt",   32'(a_count),   32'd0);
        chk("ar_empty", 32'(a_empty),   32'd1);
        chk("ar_rv",    32'(a_r_valid), 32'd0);
        chk("ar_rd",    32'(a_r_data),  32'd0);
        chk("ar_b_cnt", 32'(b_count),   32'd0);
        @(negedge clk);
        rst = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
